// File: rtl/arb_mux_reg_pkg.sv
// Shared definitions for the registered arbitrating multiplexer and its sibling selector blocks.
// Holds the mode encodings and the channel-index width helper.
package arb_mux_reg_pkg;

  localparam int MUX_MODE_FIXED = 0;
  localparam int MUX_MODE_RR    = 1;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Index width for n channels; a single channel still needs one bit for out_ch.
  function automatic int ch_w_calc(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_reg_pick.sv
// Combinational arbiter: picks one requester by fixed priority or round-robin from a start pointer.
// Separated from the datapath so other selector blocks can reuse it.
module arb_pick
  import arb_mux_reg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  arb_mode_e         mode,
  output logic [CH_W-1:0]   grant,
  output logic              any_req
);

  // rr_idx[k] is the channel visited k steps after ptr, wrapping at NUM_CH.
  logic [CH_W-1:0] rr_idx [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
      assign rr_idx[gi] = CH_W'((int'(ptr) + gi) % NUM_CH);
    end
  endgenerate

  assign any_req = |req;

  // Scan from the lowest-priority candidate upward so the highest-priority hit wins.
  always_comb begin
    grant = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mode == ARB_FIXED) begin
        if (req[k]) grant = CH_W'(k);
      end else begin
        if (req[rr_idx[k]]) grant = rr_idx[k];
      end
    end
  end

endmodule

// File: rtl/arb_mux_reg.sv
// Registered N-channel multiplexer with valid/ready on every input and on the output.
// One word per cycle when the consumer is always ready; holds the word while stalled.
module arb_mux_reg
  import arb_mux_reg_pkg::*;
#(
  parameter int DATA_W = 5,
  parameter int NUM_CH = 4,
  parameter int MODE   = 0,
  parameter int CH_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  generate
    if (CH_W != ch_w_calc(NUM_CH)) begin : g_bad_ch_w
      $error("arb_mux_reg: CH_W must equal max(1, ceil(log2(NUM_CH)))");
    end
  endgenerate

  // With a single channel there is nothing to rotate, so round-robin collapses to fixed.
  localparam arb_mode_e PICK_MODE =
    (MODE == MUX_MODE_RR && NUM_CH > 1) ? ARB_RR : ARB_FIXED;

  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   grant;
  logic              any_req;
  logic              load_en;
  logic              take;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [DATA_W-1:0] sel_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*DATA_W +: DATA_W];
      assign in_ready[gi] = !reset && load_en && in_valid[gi] && (grant == CH_W'(gi));
    end
  endgenerate

  arb_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .mode    (PICK_MODE),
    .grant   (grant),
    .any_req (any_req)
  );

  assign load_en  = !out_valid || out_ready;
  assign take     = load_en && any_req;
  assign sel_data = ch_data[grant];

  // A new word takes priority over draining, so a simultaneous in/out accept keeps out_valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (PICK_MODE == ARB_RR && take) begin
      ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: one fixed-priority and one round-robin instance side by side.
module tb_arb_mux_reg;

  localparam int DW = 5;
  localparam int NC = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;

  logic [NC-1:0]    f_valid, f_ready, r_valid, r_ready;
  logic [NC*DW-1:0] f_data, r_data;
  logic             f_ovalid, f_oready, r_ovalid, r_oready;
  logic [DW-1:0]    f_odata, r_odata;
  logic [CW-1:0]    f_och, r_och;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  arb_mux_reg #(.DATA_W(DW), .NUM_CH(NC), .MODE(0), .CH_W(CW)) u_fix (
    .clk(clk), .reset(reset), .in_valid(f_valid), .in_data(f_data), .in_ready(f_ready),
    .out_valid(f_ovalid), .out_data(f_odata), .out_ch(f_och), .out_ready(f_oready)
  );

  arb_mux_reg #(.DATA_W(DW), .NUM_CH(NC), .MODE(1), .CH_W(CW)) u_rr (
    .clk(clk), .reset(reset), .in_valid(r_valid), .in_data(r_data), .in_ready(r_ready),
    .out_valid(r_ovalid), .out_data(r_odata), .out_ch(r_och), .out_ready(r_oready)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    f_valid = 4'b1111; r_valid = 4'b1111;
    f_data = {5'h04, 5'h03, 5'h02, 5'h01}; r_data = f_data;
    f_oready = 1'b1; r_oready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++; if (f_ready !== 4'b0000) begin miss++; $display("FAIL reset_in_ready_fix: got %b want 0000", f_ready); end
      vec++; if (r_ready !== 4'b0000) begin miss++; $display("FAIL reset_in_ready_rr: got %b want 0000", r_ready); end
      vec++; if (f_ovalid !== 1'b0 || f_odata !== 5'h00 || f_och !== 2'd0) begin
        miss++; $display("FAIL reset_out_fix: got v=%b d=%h ch=%0d want 0 00 0", f_ovalid, f_odata, f_och); end
      vec++; if (r_ovalid !== 1'b0 || r_odata !== 5'h00 || r_och !== 2'd0) begin
        miss++; $display("FAIL reset_out_rr: got v=%b d=%h ch=%0d want 0 00 0", r_ovalid, r_odata, r_och); end
    end
    f_valid = 4'b0001; f_data = {5'h00, 5'h00, 5'h00, 5'h15}; f_oready = 1'b0;
    r_valid = 4'b0000;
    reset = 1'b0;
    tick();
    vec++; if (f_ovalid !== 1'b1 || f_odata !== 5'h15) begin
      miss++; $display("FAIL reset_preload: got v=%b d=%h want 1 15", f_ovalid, f_odata); end
    f_valid = 4'b0000;
    #1 reset = 1'b1;
    #1;
    vec++; if (f_ovalid !== 1'b0 || f_odata !== 5'h00) begin
      miss++; $display("FAIL reset_async: got v=%b d=%h want 0 00", f_ovalid, f_odata); end
    #1 reset = 1'b0;
    f_oready = 1'b1;
    tick();
    vec++; if (f_ovalid !== 1'b0) begin miss++; $display("FAIL reset_after_async: got v=%b want 0", f_ovalid); end
  endtask

  task automatic test_fixed_priority();
    f_valid = 4'b1010; f_data = {5'h1F, 5'h00, 5'h11, 5'h00}; f_oready = 1'b1;
    #1;
    vec++; if (f_ready !== 4'b0010) begin miss++; $display("FAIL fixed_ready1: got %b want 0010", f_ready); end
    tick();
    vec++; if (f_ovalid !== 1'b1 || f_odata !== 5'h11 || f_och !== 2'd1) begin
      miss++; $display("FAIL fixed_word1: got v=%b d=%h ch=%0d want 1 11 1", f_ovalid, f_odata, f_och); end
    f_valid = 4'b1000;
    #1;
    vec++; if (f_ready !== 4'b1000) begin miss++; $display("FAIL fixed_ready2: got %b want 1000", f_ready); end
    tick();
    vec++; if (f_ovalid !== 1'b1 || f_odata !== 5'h1F || f_och !== 2'd3) begin
      miss++; $display("FAIL fixed_word2: got v=%b d=%h ch=%0d want 1 1f 3", f_ovalid, f_odata, f_och); end
    f_valid = 4'b0000;
    tick();
    vec++; if (f_ovalid !== 1'b0 || f_odata !== 5'h1F) begin
      miss++; $display("FAIL fixed_drain: got v=%b d=%h want 0 1f", f_ovalid, f_odata); end
  endtask

  task automatic test_round_robin();
    logic [CW-1:0] exp_ch [5];
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    r_valid = 4'b1111; r_data = {5'h03, 5'h02, 5'h01, 5'h00}; r_oready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vec++; if (r_ovalid !== 1'b1 || r_och !== exp_ch[i] || r_odata !== DW'(exp_ch[i])) begin
        miss++; $display("FAIL rr_seq%0d: got v=%b ch=%0d d=%h want 1 %0d %h",
                         i, r_ovalid, r_och, r_odata, exp_ch[i], exp_ch[i]); end
    end
    r_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    f_valid = 4'b0001; f_data = {5'h00, 5'h00, 5'h00, 5'h07}; f_oready = 1'b1;
    tick();
    f_oready = 1'b0; f_valid = 4'b0100; f_data = {5'h00, 5'h0C, 5'h00, 5'h00};
    for (int i = 0; i < 4; i++) begin
      #1;
      vec++; if (f_ready !== 4'b0000 || f_ovalid !== 1'b1 || f_odata !== 5'h07 || f_och !== 2'd0) begin
        miss++; $display("FAIL bp_stall%0d: got rdy=%b v=%b d=%h ch=%0d want 0000 1 07 0",
                         i, f_ready, f_ovalid, f_odata, f_och); end
      tick();
    end
    f_oready = 1'b1;
    #1;
    vec++; if (f_ready !== 4'b0100) begin miss++; $display("FAIL bp_release_ready: got %b want 0100", f_ready); end
    tick();
    vec++; if (f_ovalid !== 1'b1 || f_odata !== 5'h0C || f_och !== 2'd2) begin
      miss++; $display("FAIL bp_reload: got v=%b d=%h ch=%0d want 1 0c 2", f_ovalid, f_odata, f_och); end
    f_valid = 4'b0000;
    tick();
  endtask

  task automatic test_ptr_skip();
    // Pointer is 1 here; a ch2 grant moves it to 3.
    r_oready = 1'b1; r_valid = 4'b0100; r_data = {5'h13, 5'h12, 5'h11, 5'h10};
    tick();
    vec++; if (r_och !== 2'd2) begin miss++; $display("FAIL ptr_ch2: got %0d want 2", r_och); end
    r_valid = 4'b0011;
    #1;
    vec++; if (r_ready !== 4'b0001) begin miss++; $display("FAIL ptr_wrap_ready: got %b want 0001", r_ready); end
    tick();
    vec++; if (r_och !== 2'd0 || r_odata !== 5'h10) begin
      miss++; $display("FAIL ptr_wrap: got ch=%0d d=%h want 0 10", r_och, r_odata); end
    vec++; if (r_ready !== 4'b0010) begin miss++; $display("FAIL ptr_next_ready: got %b want 0010", r_ready); end
    tick();
    vec++; if (r_och !== 2'd1 || r_odata !== 5'h11) begin
      miss++; $display("FAIL ptr_next: got ch=%0d d=%h want 1 11", r_och, r_odata); end
    r_valid = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    vec++; if (r_ovalid !== 1'b0) begin miss++; $display("FAIL ptr_idle: got v=%b want 0", r_ovalid); end
    // Pointer must still be 2: search 2,3 then wraps to ch0.
    r_valid = 4'b0011;
    #1;
    vec++; if (r_ready !== 4'b0001) begin miss++; $display("FAIL ptr_after_idle_ready: got %b want 0001", r_ready); end
    tick();
    vec++; if (r_och !== 2'd0 || r_ovalid !== 1'b1) begin
      miss++; $display("FAIL ptr_after_idle: got v=%b ch=%0d want 1 0", r_ovalid, r_och); end
    r_valid = 4'b0000;
    tick();
  endtask

  task automatic test_drain();
    f_valid = 4'b0001; f_data = {5'h00, 5'h00, 5'h00, 5'h1A}; f_oready = 1'b1;
    tick();
    f_valid = 4'b0000;
    vec++; if (f_ovalid !== 1'b1 || f_odata !== 5'h1A) begin
      miss++; $display("FAIL drain_load: got v=%b d=%h want 1 1a", f_ovalid, f_odata); end
    tick();
    vec++; if (f_ovalid !== 1'b0 || f_odata !== 5'h1A || f_och !== 2'd0) begin
      miss++; $display("FAIL drain_empty: got v=%b d=%h ch=%0d want 0 1a 0", f_ovalid, f_odata, f_och); end
    vec++; if (f_ready !== 4'b0000) begin miss++; $display("FAIL drain_no_req: got %b want 0000", f_ready); end
    tick();
    vec++; if (f_ovalid !== 1'b0 || f_odata !== 5'h1A) begin
      miss++; $display("FAIL drain_hold: got v=%b d=%h want 0 1a", f_ovalid, f_odata); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_backpressure();
    test_ptr_skip();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
